microsequencer: RTL and testbench

- Generates the 8-bit `state` code consumed by the control-signal decoder. Together with the IR contents, that code fully determines every datapath strobe.
- Sequences fetch, then decode, then a per-opcode micro-step list, then back to fetch.
- Latches the opcode and operand2 so both stay stable for the whole instruction.
- Sits between the instruction register and the control decoder in the CPU top level.

---
 rtl/microsequencer_pkg.sv | 63 ++++++
 rtl/microseq_rom.sv | 81 ++++++++
 rtl/microsequencer.sv | 128 ++++++++++++
 tb/tb_microsequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/microsequencer_pkg.sv
// Shared micro-state codes, opcodes and sequencer types.
// Imported by the sequencer, its step ROM and the control decoder.
package microsequencer_pkg;

  localparam int SEQ_STATE_W   = 8;
  localparam int SEQ_MAX_STEPS = 4;
  localparam int SEQ_STEP_W    = 2;

  typedef logic [SEQ_STATE_W-1:0] code_t;

  localparam code_t STATE_FETCH_PC   = 8'h00;
  localparam code_t STATE_FETCH_INST = 8'h01;
  localparam code_t STATE_SET_REG    = 8'h02;
  localparam code_t STATE_LOAD_ADDR  = 8'h03;
  localparam code_t STATE_SET_MEM    = 8'h04;
  localparam code_t STATE_MOV_REG    = 8'h05;
  localparam code_t STATE_ALU_EXEC   = 8'h06;
  localparam code_t STATE_ALU_OUT    = 8'h07;
  localparam code_t STATE_JUMP       = 8'h08;
  localparam code_t STATE_FETCH_SP   = 8'h09;
  localparam code_t STATE_STACK_REG  = 8'h0A;
  localparam code_t STATE_STORE_PC   = 8'h0B;
  localparam code_t STATE_TMP_JUMP   = 8'h0C;
  localparam code_t STATE_INC_SP     = 8'h0D;
  localparam code_t STATE_RET        = 8'h0E;
  localparam code_t STATE_HALT       = 8'h0F;
  localparam code_t STATE_DECODE     = 8'h10;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_MOV  = 4'h4;
  localparam logic [3:0] OP_ALU  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_PUSH = 4'h7;
  localparam logic [3:0] OP_CALL = 4'h8;
  localparam logic [3:0] OP_RET  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Jump conditions live in operand2; only the decoder evaluates them.
  localparam logic [2:0] JMP_ALWAYS = 3'd0;
  localparam logic [2:0] JMP_Z      = 3'd1;
  localparam logic [2:0] JMP_NZ     = 3'd2;
  localparam logic [2:0] JMP_C      = 3'd3;
  localparam logic [2:0] JMP_NC     = 3'd4;

  typedef enum logic [2:0] {
    PH_FETCH_PC,
    PH_FETCH_INST,
    PH_DECODE,
    PH_EXEC,
    PH_HALT
  } phase_t;

  // valid=0: step lies past the end of the opcode's list.
  typedef struct packed {
    logic  valid;
    logic  last;
    code_t code;
  } rom_out_t;

endpackage

// File: rtl/microseq_rom.sv
// Combinational step table: (opcode, step) -> (code, last, valid).
// Ports: opcode, step in; entry out.
module microseq_rom
  import microsequencer_pkg::*;
(
  input  logic [3:0]            opcode,
  input  logic [SEQ_STEP_W-1:0] step,
  output rom_out_t              entry
);

  logic [3:0][SEQ_STATE_W-1:0] seq;
  logic [2:0]                  len;

  always_comb begin
    seq = {4{STATE_FETCH_PC}};
    len = 3'd0;
    unique case (opcode)
      OP_LDI: begin
        len    = 3'd2;
        seq[0] = STATE_FETCH_PC;
        seq[1] = STATE_SET_REG;
      end
      OP_LD: begin
        len    = 3'd3;
        seq[0] = STATE_FETCH_PC;
        seq[1] = STATE_LOAD_ADDR;
        seq[2] = STATE_SET_REG;
      end
      OP_ST: begin
        len    = 3'd3;
        seq[0] = STATE_FETCH_PC;
        seq[1] = STATE_LOAD_ADDR;
        seq[2] = STATE_SET_MEM;
      end
      OP_MOV: begin
        len    = 3'd1;
        seq[0] = STATE_MOV_REG;
      end
      OP_ALU: begin
        len    = 3'd2;
        seq[0] = STATE_ALU_EXEC;
        seq[1] = STATE_ALU_OUT;
      end
      OP_JMP: begin
        len    = 3'd2;
        seq[0] = STATE_FETCH_PC;
        seq[1] = STATE_JUMP;
      end
      OP_PUSH: begin
        len    = 3'd2;
        seq[0] = STATE_FETCH_SP;
        seq[1] = STATE_STACK_REG;
      end
      OP_CALL: begin
        len    = 3'd4;
        seq[0] = STATE_FETCH_SP;
        seq[1] = STATE_STORE_PC;
        seq[2] = STATE_FETCH_PC;
        seq[3] = STATE_TMP_JUMP;
      end
      OP_RET: begin
        len    = 3'd3;
        seq[0] = STATE_INC_SP;
        seq[1] = STATE_FETCH_SP;
        seq[2] = STATE_RET;
      end
      OP_HALT: begin
        len    = 3'd1;
        seq[0] = STATE_HALT;
      end
      default: begin
        len = 3'd0;
      end
    endcase

    entry.valid = {1'b0, step} < len;
    entry.last  = ({1'b0, step} + 3'd1) == len;
    entry.code  = seq[step];
  end

endmodule

// File: rtl/microsequencer.sv
// Micro-state sequencer: FETCH_PC, FETCH_INST, DECODE, opcode steps.
// Ports: clk, rst, step_en, ir in; state, operand2, instr_done, halted out.
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int STATE_W   = SEQ_STATE_W,
  parameter int MAX_STEPS = SEQ_MAX_STEPS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_en,
  input  logic [7:0]         ir,
  output logic [STATE_W-1:0] state,
  output logic [2:0]         operand2,
  output logic               instr_done,
  output logic               halted
);

  phase_t                phase_q, phase_n;
  logic [STATE_W-1:0]    state_n;
  logic [3:0]            opcode_q, opcode_n;
  logic [2:0]            opnd_n;
  logic [SEQ_STEP_W-1:0] step_q, step_n;
  logic                  last_q, last_n;
  logic                  halted_n;

  logic [SEQ_STEP_W:0]   step_inc;
  logic [3:0]            rom_op;
  logic [SEQ_STEP_W-1:0] rom_step;
  logic                  step_oor;
  rom_out_t              rom;

  logic unused_ir;
  assign unused_ir = ir[3];

  assign step_inc = {1'b0, step_q} + 1'b1;
  assign step_oor = int'(step_inc) >= MAX_STEPS;

  // In DECODE the opcode is not latched yet, so look up step 0 of ir.
  assign rom_op   = (phase_q == PH_DECODE) ? ir[7:4] : opcode_q;
  assign rom_step = (phase_q == PH_DECODE) ? '0 : step_inc[SEQ_STEP_W-1:0];

  microseq_rom u_rom (
    .opcode (rom_op),
    .step   (rom_step),
    .entry  (rom)
  );

  // Empty-list opcodes finish in DECODE; that depends on the live ir.
  assign instr_done = (phase_q == PH_DECODE && !rom.valid) ||
                      (phase_q == PH_EXEC && last_q);

  always_comb begin
    phase_n  = phase_q;
    state_n  = state;
    opcode_n = opcode_q;
    opnd_n   = operand2;
    step_n   = step_q;
    last_n   = last_q;
    if (step_en) begin
      unique case (phase_q)
        PH_FETCH_PC: begin
          phase_n = PH_FETCH_INST;
          state_n = STATE_W'(STATE_FETCH_INST);
        end
        PH_FETCH_INST: begin
          phase_n = PH_DECODE;
          state_n = STATE_W'(STATE_DECODE);
        end
        PH_DECODE: begin
          opcode_n = ir[7:4];
          opnd_n   = ir[2:0];
          step_n   = '0;
          last_n   = rom.last;
          if (!rom.valid) begin
            phase_n = PH_FETCH_PC;
            state_n = STATE_W'(STATE_FETCH_PC);
          end else if (rom.code == STATE_HALT) begin
            phase_n = PH_HALT;
            state_n = STATE_W'(STATE_HALT);
          end else begin
            phase_n = PH_EXEC;
            state_n = STATE_W'(rom.code);
          end
        end
        PH_EXEC: begin
          if (last_q || !rom.valid || step_oor) begin
            phase_n = PH_FETCH_PC;
            state_n = STATE_W'(STATE_FETCH_PC);
          end else begin
            step_n  = rom_step;
            last_n  = rom.last;
            state_n = STATE_W'(rom.code);
          end
        end
        PH_HALT: begin
          phase_n = PH_HALT;
        end
        default: begin
          phase_n = PH_FETCH_PC;
          state_n = STATE_W'(STATE_FETCH_PC);
        end
      endcase
    end
    halted_n = (phase_n == PH_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH_FETCH_PC;
      state    <= STATE_W'(STATE_FETCH_PC);
      opcode_q <= '0;
      operand2 <= '0;
      step_q   <= '0;
      last_q   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      phase_q  <= phase_n;
      state    <= state_n;
      opcode_q <= opcode_n;
      operand2 <= opnd_n;
      step_q   <= step_n;
      last_q   <= last_n;
      halted   <= halted_n;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer.
// Table of instructions plus hand sequences for stall, halt and reset.
module tb_microsequencer;
  import microsequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       step_en;
  logic [7:0] ir;
  logic [7:0] state;
  logic [2:0] operand2;
  logic       instr_done;
  logic       halted;

  always #5 clk = ~clk;

  microsequencer dut (
    .clk        (clk),
    .rst        (rst),
    .step_en    (step_en),
    .ir         (ir),
    .state      (state),
    .operand2   (operand2),
    .instr_done (instr_done),
    .halted     (halted)
  );

  typedef struct {
    string      tag;
    logic [7:0] st;
    logic       done;
    logic [2:0] opnd;
    logic       halt;
    logic       chk_done;
  } exp_t;

  typedef struct {
    logic [7:0]      ir;
    int              n;
    logic [3:0][7:0] s;
  } vec_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [2:0] prev_opnd;
  vec_t       tbl[12];

  function automatic vec_t mk(input logic [7:0] i, input int n,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
    vec_t v;
    v.ir   = i;
    v.n    = n;
    v.s[0] = a;
    v.s[1] = b;
    v.s[2] = c;
    v.s[3] = d;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [7:0] st,
                     input logic done, input logic [2:0] opnd,
                     input logic halt, input logic chk_done);
    exp_t e;
    exp_t g;
    e.tag      = tag;
    e.st       = st;
    e.done     = done;
    e.opnd     = opnd;
    e.halt     = halt;
    e.chk_done = chk_done;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    checks++;
    if (state !== g.st || operand2 !== g.opnd || halted !== g.halt ||
        (g.chk_done && instr_done !== g.done)) begin
      errors++;
      $display("FAIL %s: got st=%h op2=%0d done=%b halt=%b want st=%h op2=%0d done=%b halt=%b",
               g.tag, state, operand2, instr_done, halted,
               g.st, g.opnd, g.done, g.halt);
    end
  endtask

  task automatic run_instr(input vec_t v);
    logic [2:0] nop;
    nop = v.ir[2:0];
    ir  = v.ir;
    chk("fetch_inst", STATE_FETCH_INST, 1'b0, prev_opnd, 1'b0, 1'b1);
    chk("decode", STATE_DECODE, v.n == 0, prev_opnd, 1'b0, 1'b1);
    for (int i = 0; i < v.n; i++) begin
      chk($sformatf("ir%h_step%0d", v.ir, i), v.s[i], i == v.n - 1,
          nop, 1'b0, 1'b1);
    end
    chk($sformatf("ir%h_end", v.ir), STATE_FETCH_PC, 1'b0, nop, 1'b0, 1'b1);
    prev_opnd = nop;
  endtask

  initial begin
    tbl[0]  = mk(8'h00, 0, 8'h0, 8'h0, 8'h0, 8'h0);
    tbl[1]  = mk(8'h53, 2, STATE_ALU_EXEC, STATE_ALU_OUT, 8'h0, 8'h0);
    tbl[2]  = mk(8'h82, 4, STATE_FETCH_SP, STATE_STORE_PC,
                 STATE_FETCH_PC, STATE_TMP_JUMP);
    tbl[3]  = mk(8'h14, 2, STATE_FETCH_PC, STATE_SET_REG, 8'h0, 8'h0);
    tbl[4]  = mk(8'h26, 3, STATE_FETCH_PC, STATE_LOAD_ADDR,
                 STATE_SET_REG, 8'h0);
    tbl[5]  = mk(8'h31, 3, STATE_FETCH_PC, STATE_LOAD_ADDR,
                 STATE_SET_MEM, 8'h0);
    tbl[6]  = mk(8'h47, 1, STATE_MOV_REG, 8'h0, 8'h0, 8'h0);
    tbl[7]  = mk(8'h65, 2, STATE_FETCH_PC, STATE_JUMP, 8'h0, 8'h0);
    tbl[8]  = mk(8'h7A, 2, STATE_FETCH_SP, STATE_STACK_REG, 8'h0, 8'h0);
    tbl[9]  = mk(8'h9C, 3, STATE_INC_SP, STATE_FETCH_SP,
                 STATE_RET, 8'h0);
    tbl[10] = mk(8'hB7, 0, 8'h0, 8'h0, 8'h0, 8'h0);
    tbl[11] = mk(8'hED, 0, 8'h0, 8'h0, 8'h0, 8'h0);

    rst       = 1'b1;
    step_en   = 1'b1;
    ir        = 8'h00;
    prev_opnd = 3'd0;
    chk("reset", STATE_FETCH_PC, 1'b0, 3'd0, 1'b0, 1'b1);
    chk("reset2", STATE_FETCH_PC, 1'b0, 3'd0, 1'b0, 1'b1);
    rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      run_instr(tbl[k]);
    end

    // LD with a 3-cycle stall in LOAD_ADDR; ir changes mid-stall.
    ir = 8'h21;
    chk("ld_fi", STATE_FETCH_INST, 1'b0, prev_opnd, 1'b0, 1'b1);
    chk("ld_dec", STATE_DECODE, 1'b0, prev_opnd, 1'b0, 1'b1);
    chk("ld_s0", STATE_FETCH_PC, 1'b0, 3'd1, 1'b0, 1'b1);
    chk("ld_s1", STATE_LOAD_ADDR, 1'b0, 3'd1, 1'b0, 1'b1);
    step_en = 1'b0;
    ir      = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      chk("ld_stall", STATE_LOAD_ADDR, 1'b0, 3'd1, 1'b0, 1'b1);
    end
    step_en = 1'b1;
    chk("ld_s2", STATE_SET_REG, 1'b1, 3'd1, 1'b0, 1'b1);
    chk("ld_end", STATE_FETCH_PC, 1'b0, 3'd1, 1'b0, 1'b1);
    prev_opnd = 3'd1;

    // HALT is sticky until reset.
    ir = 8'hF0;
    chk("h_fi", STATE_FETCH_INST, 1'b0, prev_opnd, 1'b0, 1'b1);
    chk("h_dec", STATE_DECODE, 1'b0, prev_opnd, 1'b0, 1'b1);
    chk("halt", STATE_HALT, 1'b0, 3'd0, 1'b1, 1'b0);
    ir = 8'h10;
    for (int i = 0; i < 10; i++) begin
      step_en = 1'(i % 2);
      chk("halt_hold", STATE_HALT, 1'b0, 3'd0, 1'b1, 1'b0);
    end
    step_en = 1'b1;
    rst     = 1'b1;
    chk("halt_rst", STATE_FETCH_PC, 1'b0, 3'd0, 1'b0, 1'b1);
    rst       = 1'b0;
    prev_opnd = 3'd0;

    // ST with reset during SET_MEM, then undefined opcode as NOP.
    ir = 8'h35;
    chk("st_fi", STATE_FETCH_INST, 1'b0, 3'd0, 1'b0, 1'b1);
    chk("st_dec", STATE_DECODE, 1'b0, 3'd0, 1'b0, 1'b1);
    chk("st_s0", STATE_FETCH_PC, 1'b0, 3'd5, 1'b0, 1'b1);
    chk("st_s1", STATE_LOAD_ADDR, 1'b0, 3'd5, 1'b0, 1'b1);
    chk("st_s2", STATE_SET_MEM, 1'b1, 3'd5, 1'b0, 1'b1);
    rst = 1'b1;
    chk("st_rst", STATE_FETCH_PC, 1'b0, 3'd0, 1'b0, 1'b1);
    rst = 1'b0;
    ir  = 8'hB7;
    chk("b7_fi", STATE_FETCH_INST, 1'b0, 3'd0, 1'b0, 1'b1);
    chk("b7_dec", STATE_DECODE, 1'b1, 3'd0, 1'b0, 1'b1);
    chk("b7_end", STATE_FETCH_PC, 1'b0, 3'd7, 1'b0, 1'b1);

    // Reset during ALU_EXEC abandons ALU_OUT.
    ir = 8'h53;
    chk("alu_fi", STATE_FETCH_INST, 1'b0, 3'd7, 1'b0, 1'b1);
    chk("alu_dec", STATE_DECODE, 1'b0, 3'd7, 1'b0, 1'b1);
    chk("alu_s0", STATE_ALU_EXEC, 1'b0, 3'd3, 1'b0, 1'b1);
    rst = 1'b1;
    chk("alu_rst", STATE_FETCH_PC, 1'b0, 3'd0, 1'b0, 1'b1);
    rst       = 1'b0;
    prev_opnd = 3'd0;

    // Stall in FETCH_PC, then a plain NOP.
    step_en = 1'b0;
    chk("fpc_hold", STATE_FETCH_PC, 1'b0, 3'd0, 1'b0, 1'b1);
    chk("fpc_hold2", STATE_FETCH_PC, 1'b0, 3'd0, 1'b0, 1'b1);
    step_en = 1'b1;
    run_instr(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
